// File: rtl/pc_fetch_unit.sv
// MIPS32 instruction-fetch sequencer: owns the PC, runs a hold-until-ready
// request to instruction memory and presents one instruction at a time to decode.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_offset,
  input  logic        i_jump,
  input  logic [25:0] i_jump_target,
  input  logic        i_jump_reg,
  input  logic [31:0] i_reg_target,
  input  logic        i_exc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  output logic        o_flush
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr_q;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_flush;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_addr_q_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_instr_pc_nxt;
  logic        w_instr_valid_nxt;
  logic        w_flush_nxt;
  logic        w_req;
  logic [31:0] w_addr;

  logic        w_accept;
  logic        w_slot_free;
  logic        w_redirect;
  logic [31:0] w_p4;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_jr_tgt;
  logic [31:0] w_redirect_tgt;

  assign w_accept    = r_instr_valid && !i_stall;
  assign w_slot_free = !r_instr_valid || !i_stall;
  assign w_redirect  = w_accept && (i_jump_reg || i_jump || i_branch_taken);

  // Redirect targets are relative to the presented instruction; no delay slot.
  assign w_p4         = r_instr_pc + 32'd4;
  assign w_branch_tgt = w_p4 + {{14{i_branch_offset[15]}}, i_branch_offset, 2'b00};
  assign w_jump_tgt   = {w_p4[31:28], i_jump_target, 2'b00};
  assign w_jr_tgt     = i_reg_target & ~32'd3;

  always_comb begin
    if (i_jump_reg)
      w_redirect_tgt = w_jr_tgt;
    else if (i_jump)
      w_redirect_tgt = w_jump_tgt;
    else
      w_redirect_tgt = w_branch_tgt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_addr_q_nxt      = r_addr_q;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_flush_nxt       = 1'b0;
    w_req             = 1'b0;
    w_addr            = r_pc;

    unique case (r_state)
      S_FETCH: begin
        w_addr = r_pc;
        w_req  = w_slot_free && !w_redirect && !i_exc;
        if (i_exc || w_redirect) begin
          w_pc_nxt          = i_exc ? EXC_VECTOR : w_redirect_tgt;
          w_instr_valid_nxt = 1'b0;
          w_flush_nxt       = 1'b1;
        end else if (w_req) begin
          w_addr_q_nxt = r_pc;
          if (i_imem_ready) begin
            w_instr_nxt       = i_imem_rdata;
            w_instr_pc_nxt    = r_pc;
            w_instr_valid_nxt = 1'b1;
            w_pc_nxt          = r_pc + 32'd4;
          end else begin
            // Slot was either empty or just accepted, so it is empty while waiting.
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        w_req  = 1'b1;
        w_addr = r_addr_q;
        if (i_exc) begin
          w_pc_nxt          = EXC_VECTOR;
          w_instr_valid_nxt = 1'b0;
          w_flush_nxt       = 1'b1;
          w_state_nxt       = i_imem_ready ? S_FETCH : S_DRAIN;
        end else if (i_imem_ready) begin
          w_instr_nxt       = i_imem_rdata;
          w_instr_pc_nxt    = r_addr_q;
          w_instr_valid_nxt = 1'b1;
          w_pc_nxt          = r_addr_q + 32'd4;
          w_state_nxt       = S_FETCH;
        end
      end

      // The abandoned request must still complete before a new one can start.
      S_DRAIN: begin
        w_req  = 1'b1;
        w_addr = r_addr_q;
        if (i_exc) begin
          w_pc_nxt          = EXC_VECTOR;
          w_instr_valid_nxt = 1'b0;
          w_flush_nxt       = 1'b1;
        end
        if (i_imem_ready)
          w_state_nxt = S_FETCH;
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    if (i_rst)
      w_req = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_addr_q      <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_addr_q      <= w_addr_q_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_flush       <= w_flush_nxt;
    end
  end

  assign o_imem_req    = w_req;
  assign o_imem_addr   = w_addr;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_flush       = r_flush;

endmodule
